// File: rtl/biu_constants_pkg.sv
// Bus interface constants shared by the core's memory units and the
// memory-side responders.
//   biu_size_t : access size encoding on the dmem_* bus
//   biu_be     : byte-enable mask for a size and the low two address bits
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011,
    QWORD = 3'b100
  } biu_size_t;

  // Lanes follow the byte address; sizes wider than a word enable nothing.
  function automatic logic [3:0] biu_be(input biu_size_t size, input logic [1:0] adr);
    case (size)
      BYTE:    biu_be = 4'b0001 << adr;
      HWORD:   biu_be = 4'b0011 << adr;
      WORD:    biu_be = 4'b1111;
      default: biu_be = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_resp_pkg.sv
// Local definitions for the data memory responder.
//   dmem_resp_state_t : responder FSM states
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

endpackage

// File: rtl/dmem_ram_1rw.sv
// Single-port RAM with byte-enable write and synchronous read.
// A write returns the word as it was before the write (read-before-write).
//   clk   : clock
//   en    : access enable (read always happens, write if we)
//   we    : write enable
//   be    : byte lane enables
//   addr  : word index
//   wdata : lane-positioned write data
//   rdata : registered read data, held while en is low
module dmem_ram_1rw #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [XLEN/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        for (int i = 0; i < XLEN/8; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_sram_responder.sv
// Memory-side responder for the core's dmem_* request/ack bus, backed by a
// local byte-writable SRAM with configurable latency and wait injection.
//   clk, rstn        : clock, asynchronous active-low reset
//   dmem_req/adr/d   : request, byte address, lane-positioned write data
//   dmem_we/size     : write select, access size
//   dmem_q           : read data (pre-write word on writes), valid with ack
//   dmem_ack/err     : one-cycle completion / error completion strobes
//   dmem_misaligned  : combinational misalignment flag (IDLE only)
//   dmem_page_fault  : always 0, there is no MMU
//   inject_wait      : holds the BUSY countdown while high
module dmem_sram_responder
  import biu_constants_pkg::*;
  import dmem_resp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 'h0,
  parameter int LATENCY   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            dmem_we,
  input  biu_size_t       dmem_size,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_err,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault,
  input  logic            inject_wait
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // Base is aligned to the RAM size, so the range check is a tag compare
  // on the bits above the word index and can never wrap.
  localparam logic [XLEN-AW-3:0] BASE_TAG = (XLEN-AW-2)'(BASE_ADDR >> (AW + 2));

  dmem_resp_state_t state, next_state;
  logic [CW-1:0]    cnt;
  logic [XLEN-1:0]  cap_adr, cap_d;
  logic             cap_we;
  biu_size_t        cap_size;
  logic             q_valid;

  logic [XLEN-1:0]  acc_adr, acc_d;
  logic             acc_we;
  biu_size_t        acc_size;
  logic             acc_ok;
  logic             accept, resp_entry;
  logic             ram_en;
  logic [XLEN-1:0]  ram_rdata;

  // With LATENCY=1 the access commits on the accept edge itself, before the
  // capture registers load, so the live bus is used while still in IDLE.
  always_comb begin
    acc_adr  = cap_adr;
    acc_d    = cap_d;
    acc_we   = cap_we;
    acc_size = cap_size;
    if (state == IDLE) begin
      acc_adr  = dmem_adr;
      acc_d    = dmem_d;
      acc_we   = dmem_we;
      acc_size = dmem_size;
    end
    acc_ok = (acc_adr[XLEN-1:AW+2] == BASE_TAG) &&
             ((acc_size == BYTE) || (acc_size == HWORD) || (acc_size == WORD));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (LATENCY > 1) ? BUSY : RESP;
      BUSY:    if (!inject_wait && cnt == CW'(1)) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The RAM write is gated by rstn so a reset on the commit edge drops it.
  always_comb begin
    dmem_misaligned = dmem_req && (state == IDLE) &&
                      (((dmem_size == HWORD) && dmem_adr[0]) ||
                       ((dmem_size == WORD) && (|dmem_adr[1:0])));
    accept          = (state == IDLE) && dmem_req && !dmem_misaligned;
    resp_entry      = (next_state == RESP);
    ram_en          = resp_entry && acc_ok && rstn;
    dmem_q          = q_valid ? ram_rdata : '0;
    dmem_page_fault = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      cap_adr  <= '0;
      cap_d    <= '0;
      cap_we   <= 1'b0;
      cap_size <= BYTE;
      dmem_ack <= 1'b0;
      dmem_err <= 1'b0;
      q_valid  <= 1'b0;
    end else begin
      dmem_ack <= resp_entry && acc_ok;
      dmem_err <= resp_entry && !acc_ok;
      if (resp_entry) q_valid <= acc_ok;
      if (accept) begin
        cap_adr  <= dmem_adr;
        cap_d    <= dmem_d;
        cap_we   <= dmem_we;
        cap_size <= dmem_size;
        cnt      <= CW'(LATENCY - 1);
      end else if (state == BUSY && !inject_wait) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  dmem_ram_1rw #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (acc_we),
    .be    (biu_be(acc_size, acc_adr[1:0])),
    .addr  (acc_adr[AW+1:2]),
    .wdata (acc_d),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Directed bench for dmem_sram_responder: unit 0 runs with LATENCY=1,
// unit 1 with LATENCY=3; both map 256 words at byte address 'h1000.
module tb_dmem_sram_responder;
  import biu_constants_pkg::*;

  logic        clk;
  logic        rstn;
  logic        req [2];
  logic [31:0] adr [2];
  logic [31:0] d [2];
  logic        we [2];
  biu_size_t   size [2];
  logic [31:0] q [2];
  logic        ack [2];
  logic        err [2];
  logic        mis [2];
  logic        pf [2];
  logic        iw [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] rq;
  logic        rack, rerr;
  int          cyc;
  int          hits;
  int          ack_at [$];

  dmem_sram_responder #(.XLEN(32), .DEPTH(256), .BASE_ADDR('h1000), .LATENCY(1)) dut0 (
    .clk(clk), .rstn(rstn), .dmem_req(req[0]), .dmem_adr(adr[0]), .dmem_d(d[0]),
    .dmem_we(we[0]), .dmem_size(size[0]), .dmem_q(q[0]), .dmem_ack(ack[0]),
    .dmem_err(err[0]), .dmem_misaligned(mis[0]), .dmem_page_fault(pf[0]),
    .inject_wait(iw[0])
  );

  dmem_sram_responder #(.XLEN(32), .DEPTH(256), .BASE_ADDR('h1000), .LATENCY(3)) dut1 (
    .clk(clk), .rstn(rstn), .dmem_req(req[1]), .dmem_adr(adr[1]), .dmem_d(d[1]),
    .dmem_we(we[1]), .dmem_size(size[1]), .dmem_q(q[1]), .dmem_ack(ack[1]),
    .dmem_err(err[1]), .dmem_misaligned(mis[1]), .dmem_page_fault(pf[1]),
    .inject_wait(iw[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on unit u: request for a single cycle, then wait (bounded)
  // for ack/err. Cycles are counted from the accept edge. inject_wait is
  // raised at cycle ws for wl cycles when ws > 0.
  task automatic apply_stimulus(input int u, input logic w, input biu_size_t s,
                                input logic [31:0] a, input logic [31:0] data,
                                input int ws, input int wl,
                                output logic [31:0] oq, output logic oack,
                                output logic oerr, output int ocyc);
    @(negedge clk);
    req[u] = 1'b1; we[u] = w; size[u] = s; adr[u] = a; d[u] = data;
    @(posedge clk);
    #1 req[u] = 1'b0;
    ocyc = 0; oack = 1'b0; oerr = 1'b0; oq = '0;
    while (ocyc < 40 && !oack && !oerr) begin
      @(negedge clk);
      ocyc++;
      oack = ack[u]; oerr = err[u]; oq = q[u];
      if (ws > 0 && ocyc == ws) iw[u] = 1'b1;
      if (ws > 0 && ocyc == ws + wl) iw[u] = 1'b0;
    end
    iw[u] = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; adr[i] = '0; d[i] = '0; we[i] = 1'b0; size[i] = WORD; iw[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_output("reset_q0", q[0], 32'h0);
    check_output("reset_ack0", {31'd0, ack[0]}, 32'd0);
    check_output("reset_err1", {31'd0, err[1]}, 32'd0);
    check_output("reset_pf0", {31'd0, pf[0]}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // LATENCY=1 word write / read
    apply_stimulus(0, 1'b1, WORD, 32'h1010, 32'hDEADBEEF, 0, 0, rq, rack, rerr, cyc);
    check_output("w1_ack", {31'd0, rack}, 32'd1);
    check_output("w1_cycles", 32'(cyc), 32'd1);
    apply_stimulus(0, 1'b0, WORD, 32'h1010, 32'h0, 0, 0, rq, rack, rerr, cyc);
    check_output("r1_q", rq, 32'hDEADBEEF);
    check_output("r1_cycles", 32'(cyc), 32'd1);

    // Pre-write data on write acks, then byte and halfword lane writes
    apply_stimulus(0, 1'b1, WORD, 32'h1010, 32'h11223344, 0, 0, rq, rack, rerr, cyc);
    check_output("w2_prewrite_q", rq, 32'hDEADBEEF);
    apply_stimulus(0, 1'b1, BYTE, 32'h1013, 32'hAA000000, 0, 0, rq, rack, rerr, cyc);
    check_output("wb_prewrite_q", rq, 32'h11223344);
    apply_stimulus(0, 1'b0, WORD, 32'h1010, 32'h0, 0, 0, rq, rack, rerr, cyc);
    check_output("rb_q", rq, 32'hAA223344);
    apply_stimulus(0, 1'b1, HWORD, 32'h1012, 32'h55660000, 0, 0, rq, rack, rerr, cyc);
    check_output("wh_ack", {31'd0, rack}, 32'd1);
    apply_stimulus(0, 1'b0, WORD, 32'h1010, 32'h0, 0, 0, rq, rack, rerr, cyc);
    check_output("rh_q", rq, 32'h55663344);
    apply_stimulus(0, 1'b1, WORD, 32'h1000, 32'h0BADF00D, 0, 0, rq, rack, rerr, cyc);

    // Misaligned halfword held for 10 cycles: flagged, never completed
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; size[0] = HWORD; adr[0] = 32'h1001; d[0] = 32'hFFFFFFFF;
    #1 check_output("mis_hword", {31'd0, mis[0]}, 32'd1);
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[0] || err[0]) hits++;
    end
    req[0] = 1'b0;
    check_output("mis_no_resp", 32'(hits), 32'd0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; size[0] = WORD; adr[0] = 32'h1012;
    #1 check_output("mis_word", {31'd0, mis[0]}, 32'd1);
    size[0] = HWORD; adr[0] = 32'h1002;
    #1 check_output("aligned_hword", {31'd0, mis[0]}, 32'd0);
    req[0] = 1'b0;
    apply_stimulus(0, 1'b0, WORD, 32'h1000, 32'h0, 0, 0, rq, rack, rerr, cyc);
    check_output("mis_ram_unchanged", rq, 32'h0BADF00D);

    // Error completions: above range, below range, illegal size
    apply_stimulus(0, 1'b0, WORD, 32'h1400, 32'h0, 0, 0, rq, rack, rerr, cyc);
    check_output("oor_err", {31'd0, rerr}, 32'd1);
    check_output("oor_ack", {31'd0, rack}, 32'd0);
    check_output("oor_q", rq, 32'h0);
    apply_stimulus(0, 1'b0, WORD, 32'h0FFC, 32'h0, 0, 0, rq, rack, rerr, cyc);
    check_output("below_err", {31'd0, rerr}, 32'd1);
    apply_stimulus(0, 1'b1, DWORD, 32'h1010, 32'hFFFFFFFF, 0, 0, rq, rack, rerr, cyc);
    check_output("dword_err", {31'd0, rerr}, 32'd1);
    check_output("dword_q", rq, 32'h0);
    apply_stimulus(0, 1'b0, WORD, 32'h1010, 32'h0, 0, 0, rq, rack, rerr, cyc);
    check_output("dword_no_write", rq, 32'h55663344);

    // LATENCY=3 with two injected wait cycles, then a plain read
    apply_stimulus(1, 1'b1, WORD, 32'h1020, 32'hCAFEF00D, 1, 2, rq, rack, rerr, cyc);
    check_output("l3_wait_ack", {31'd0, rack}, 32'd1);
    check_output("l3_wait_cycles", 32'(cyc), 32'd5);
    apply_stimulus(1, 1'b0, WORD, 32'h1020, 32'h0, 0, 0, rq, rack, rerr, cyc);
    check_output("l3_read_cycles", 32'(cyc), 32'd3);
    check_output("l3_read_q", rq, 32'hCAFEF00D);

    // Request held high: completions spaced LATENCY+1 apart
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; size[1] = WORD; adr[1] = 32'h1020;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (ack[1]) ack_at.push_back(i);
    end
    req[1] = 1'b0;
    check_output("b2b_count", 32'(ack_at.size()), 32'd3);
    if (ack_at.size() >= 2) begin
      check_output("b2b_first", 32'(ack_at[0]), 32'd3);
      check_output("b2b_spacing", 32'(ack_at[1] - ack_at[0]), 32'd4);
    end
    repeat (5) @(negedge clk);

    // Reset during BUSY of a write drops it; the next access is normal
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; size[1] = WORD; adr[1] = 32'h1020; d[1] = 32'h12345678;
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] || err[1]) hits++;
    end
    check_output("rst_no_ack", 32'(hits), 32'd0);
    apply_stimulus(1, 1'b0, WORD, 32'h1020, 32'h0, 0, 0, rq, rack, rerr, cyc);
    check_output("rst_word_kept", rq, 32'hCAFEF00D);
    check_output("rst_next_cycles", 32'(cyc), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
